// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round helper functions
// used by the block engine and its combinational round.
package sha1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        UPDATE,
        OUT
    } state_t;

    localparam logic [159:0] H_INIT = {
        32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
    };

    localparam logic [31:0] K_00_19 = 32'h5A827999;
    localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

    localparam logic [6:0] LAST_ROUND = 7'd79;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Ch for the first quarter, Maj for the third, Parity otherwise.
    function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)
            return (b & c) | (~b & d);
        else if (t < 7'd40)
            return b ^ c ^ d;
        else if (t < 7'd60)
            return (b & c) | (b & d) | (c & d);
        else
            return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] k_sel(input logic [6:0] t);
        if (t < 7'd20)
            return K_00_19;
        else if (t < 7'd40)
            return K_20_39;
        else if (t < 7'd60)
            return K_40_59;
        else
            return K_60_79;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// Combinational single SHA-1 round: advances the A..E working variables
// by one step using the current schedule word and round index.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] w,
    input  logic [6:0]  t,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next,
    output logic [31:0] e_next
);

    logic [31:0] temp;

    always_comb begin
        temp = rotl(a, 5) + f_sel(t, b, c, d) + e + k_sel(t) + w;
    end

    assign a_next = temp;
    assign b_next = a;
    assign c_next = rotl(b, 30);
    assign d_next = c;
    assign e_next = d;

endmodule

// File: rtl/sha1_block_engine.sv
// Iterative SHA-1 compression engine: one round per clock, chains the
// hash across blocks and presents the digest after each message's last block.
module sha1_block_engine
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    output logic         o_tready_in,
    input  logic         i_tvalid_in,
    input  logic [511:0] i_tdata_in,
    input  logic         i_tlast_in,
    input  logic         i_tready_out,
    output logic         o_tvalid_out,
    output logic [159:0] o_tdata_out
);

    state_t       state;
    logic [31:0]  window [16];
    logic [159:0] h_reg;
    logic [31:0]  a, b, c, d, e;
    logic [6:0]   t;
    logic         last_flag;

    logic [31:0]  a_next, b_next, c_next, d_next, e_next;
    logic [31:0]  w_new;
    logic [159:0] h_sum;

    sha1_round u_round (
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .e      (e),
        .w      (window[0]),
        .t      (t),
        .a_next (a_next),
        .b_next (b_next),
        .c_next (c_next),
        .d_next (d_next),
        .e_next (e_next)
    );

    // Indices are relative to the current window, whose word 0 is W[t].
    assign w_new = rotl(window[13] ^ window[8] ^ window[2] ^ window[0], 1);

    assign h_sum = {h_reg[159:128] + a, h_reg[127:96] + b, h_reg[95:64] + c,
                    h_reg[63:32] + d, h_reg[31:0] + e};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            o_tready_in  <= 1'b0;
            o_tvalid_out <= 1'b0;
            o_tdata_out  <= '0;
            h_reg        <= H_INIT;
            t            <= '0;
            last_flag    <= 1'b0;
            a            <= '0;
            b            <= '0;
            c            <= '0;
            d            <= '0;
            e            <= '0;
            for (int i = 0; i < 16; i++)
                window[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (o_tready_in && i_tvalid_in) begin
                        for (int i = 0; i < 16; i++)
                            window[i] <= i_tdata_in[511 - 32*i -: 32];
                        {a, b, c, d, e} <= h_reg;
                        last_flag       <= i_tlast_in;
                        t               <= '0;
                        o_tready_in     <= 1'b0;
                        state           <= ROUND;
                    end else begin
                        o_tready_in <= 1'b1;
                    end
                end

                ROUND: begin
                    {a, b, c, d, e} <= {a_next, b_next, c_next, d_next, e_next};
                    for (int i = 0; i < 15; i++)
                        window[i] <= window[i + 1];
                    window[15] <= w_new;
                    if (t == LAST_ROUND)
                        state <= UPDATE;
                    else
                        t <= t + 7'd1;
                end

                // Final block publishes the digest and rearms H for the next message.
                UPDATE: begin
                    if (last_flag) begin
                        o_tdata_out  <= h_sum;
                        o_tvalid_out <= 1'b1;
                        h_reg        <= H_INIT;
                        state        <= OUT;
                    end else begin
                        h_reg       <= h_sum;
                        o_tready_in <= 1'b1;
                        state       <= IDLE;
                    end
                end

                OUT: begin
                    if (i_tready_out) begin
                        o_tvalid_out <= 1'b0;
                        o_tready_in  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_block_engine.sv
// Self-checking bench for sha1_block_engine: known-answer vectors, backpressure,
// mid-round reset and randomized throttled traffic against a SHA-1 reference model.
module tb_sha1_block_engine;

    localparam logic [159:0] H_START = {
        32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0
    };
    // Acceptance in cycle T, result in cycle T+82: 81 edges after the accepting edge.
    localparam int LAT_EDGES  = 81;
    localparam int WAIT_LIMIT = 400;
    localparam int NUM_RAND   = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         o_tready_in;
    logic         i_tvalid_in = 1'b0;
    logic [511:0] i_tdata_in = '0;
    logic         i_tlast_in = 1'b0;
    logic         i_tready_out = 1'b0;
    logic         o_tvalid_out;
    logic [159:0] o_tdata_out;

    int errors = 0;
    int checks = 0;

    byte unsigned msg_q[$];
    logic [511:0] pad_q[$];
    logic [511:0] rnd_blk_q[$];
    logic         rnd_last_q[$];
    logic [159:0] exp_q[$];
    logic [159:0] got_q[$];

    typedef struct {
        string        name;
        string        text;
        logic [159:0] digest;
    } vec_t;

    vec_t vecs[3];

    sha1_block_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_tready_in  (o_tready_in),
        .i_tvalid_in  (i_tvalid_in),
        .i_tdata_in   (i_tdata_in),
        .i_tlast_in   (i_tlast_in),
        .i_tready_out (i_tready_out),
        .o_tvalid_out (o_tvalid_out),
        .o_tdata_out  (o_tdata_out)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] ref_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] x, va, vb, vc, vd, ve, f, k, tmp;
        for (int i = 0; i < 16; i++)
            w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        {va, vb, vc, vd, ve} = hin;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin
                f = (vb & vc) | (~vb & vd);
                k = 32'h5a827999;
            end else if (i < 40) begin
                f = vb ^ vc ^ vd;
                k = 32'h6ed9eba1;
            end else if (i < 60) begin
                f = (vb & vc) | (vb & vd) | (vc & vd);
                k = 32'h8f1bbcdc;
            end else begin
                f = vb ^ vc ^ vd;
                k = 32'hca62c1d6;
            end
            tmp = {va[26:0], va[31:27]} + f + ve + k + w[i];
            ve = vd;
            vd = vc;
            vc = {vb[1:0], vb[31:2]};
            vb = va;
            va = tmp;
        end
        return {hin[159:128] + va, hin[127:96] + vb, hin[95:64] + vc,
                hin[63:32] + vd, hin[31:0] + ve};
    endfunction

    function automatic void load_text(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++)
            msg_q.push_back(s[i]);
    endfunction

    // Standard SHA-1 padding of msg_q into 512-bit blocks in pad_q.
    function automatic void pad_msg();
        byte unsigned p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56)
            p.push_back(8'h00);
        for (int i = 7; i >= 0; i--)
            p.push_back(bitlen[8*i +: 8]);
        pad_q.delete();
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++)
                blk[511 - 8*j -: 8] = p[bi*64 + j];
            pad_q.push_back(blk);
        end
    endfunction

    function automatic logic [159:0] ref_digest();
        logic [159:0] hv;
        hv = H_START;
        foreach (pad_q[i])
            hv = ref_compress(hv, pad_q[i]);
        return hv;
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [511:0] blk, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        i_tvalid_in = 1'b1;
        i_tdata_in  = blk;
        i_tlast_in  = last;
        n = 0;
        while (!o_tready_in && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!o_tready_in) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no ready after %0d cycles, required ready", n);
        end else begin
            @(posedge clk);
        end
        #1;
        i_tvalid_in = 1'b0;
        i_tdata_in  = {16{$urandom}};
        i_tlast_in  = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (n < WAIT_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (o_tvalid_out)
                break;
        end
    endtask

    int           n;
    int           seen;
    int           extra;
    int           cyc;
    int           len;
    logic         stalled;
    logic [159:0] held;
    logic [159:0] exp_d;
    logic [511:0] abc_blk;
    logic [511:0] empty_blk;

    initial begin
        vecs[0] = '{name: "empty", text: "", digest: 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709};
        vecs[1] = '{name: "abc", text: "abc", digest: 160'ha9993e364706816aba3e25717850c26c9cd0d89d};
        vecs[2] = '{name: "two_block",
                    text: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
                    digest: 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1};

        // Reset state and registered ready rising one edge after release.
        #12;
        checkOutput("reset_tdata", o_tdata_out, '0);
        checkOutput("reset_flags", 160'({o_tvalid_out, o_tready_in}), '0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("ready_after_release", 160'(o_tready_in), '0);
        @(posedge clk);
        #1 checkOutput("ready_first_edge", 160'(o_tready_in), 160'd1);

        // Known-answer table.
        i_tready_out = 1'b1;
        for (int v = 0; v < 3; v++) begin
            load_text(vecs[v].text);
            pad_msg();
            checkOutput({"model_", vecs[v].name}, ref_digest(), vecs[v].digest);
            for (int bi = 0; bi < pad_q.size(); bi++) begin
                if (bi != pad_q.size() - 1) begin
                    applyStimulus(pad_q[bi], 1'b0, 0);
                    seen = 0;
                    n = 0;
                    while (!o_tready_in && n < WAIT_LIMIT) begin
                        @(posedge clk);
                        #1;
                        n++;
                        if (o_tvalid_out)
                            seen++;
                    end
                    checkOutput({"no_out_mid_", vecs[v].name}, 160'(seen), '0);
                    checkOutput({"mid_ready_lat_", vecs[v].name}, 160'(n), 160'(LAT_EDGES));
                end else begin
                    applyStimulus(pad_q[bi], 1'b1, 0);
                    waitValid(n);
                    checkOutput({"latency_", vecs[v].name}, 160'(n), 160'(LAT_EDGES));
                    checkOutput({"digest_", vecs[v].name}, o_tdata_out, vecs[v].digest);
                    @(posedge clk);
                    #1;
                    checkOutput({"handshake_", vecs[v].name}, 160'({o_tvalid_out, o_tready_in}), 160'b01);
                end
            end
        end

        // Backpressure: abc digest held while the empty message waits upstream.
        load_text("abc");
        pad_msg();
        abc_blk = pad_q[0];
        load_text("");
        pad_msg();
        empty_blk = pad_q[0];
        i_tready_out = 1'b0;
        applyStimulus(abc_blk, 1'b1, 0);
        waitValid(n);
        checkOutput("bp_latency", 160'(n), 160'(LAT_EDGES));
        @(negedge clk);
        i_tvalid_in = 1'b1;
        i_tdata_in  = empty_blk;
        i_tlast_in  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checkOutput("bp_hold_data", o_tdata_out, vecs[1].digest);
            checkOutput("bp_hold_flags", 160'({o_tvalid_out, o_tready_in}), 160'b10);
        end
        i_tready_out = 1'b1;
        n = 0;
        while (!o_tready_in && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_ready_return", 160'(o_tready_in), 160'd1);
        @(posedge clk);
        #1;
        i_tvalid_in = 1'b0;
        i_tlast_in  = 1'b0;
        waitValid(n);
        checkOutput("bp_second_latency", 160'(n), 160'(LAT_EDGES));
        checkOutput("bp_second_digest", o_tdata_out, vecs[0].digest);
        @(posedge clk);

        // Asynchronous reset at round 40 aborts the block.
        applyStimulus(abc_blk, 1'b1, 0);
        repeat (40) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_tdata", o_tdata_out, '0);
        checkOutput("midreset_flags", 160'({o_tvalid_out, o_tready_in}), '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("midreset_ready", 160'(o_tready_in), 160'd1);
        applyStimulus(abc_blk, 1'b1, 0);
        waitValid(n);
        checkOutput("midreset_latency", 160'(n), 160'(LAT_EDGES));
        checkOutput("midreset_digest", o_tdata_out, vecs[1].digest);
        @(posedge clk);

        // Random padded messages with input gaps and output throttling.
        for (int m = 0; m < NUM_RAND; m++) begin
            len = $urandom_range(0, 130);
            msg_q.delete();
            for (int i = 0; i < len; i++)
                msg_q.push_back(8'($urandom));
            pad_msg();
            exp_q.push_back(ref_digest());
            foreach (pad_q[i]) begin
                rnd_blk_q.push_back(pad_q[i]);
                rnd_last_q.push_back(i == pad_q.size() - 1);
            end
        end
        stalled = 1'b0;
        held = '0;
        cyc = 0;
        fork
            begin
                foreach (rnd_blk_q[i])
                    applyStimulus(rnd_blk_q[i], rnd_last_q[i], $urandom_range(0, 4));
            end
            begin
                while (got_q.size() < NUM_RAND && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (stalled) begin
                        checkOutput("rnd_hold_valid", 160'(o_tvalid_out), 160'd1);
                        checkOutput("rnd_hold_data", o_tdata_out, held);
                        stalled = 1'b0;
                    end
                    i_tready_out = 1'($urandom_range(0, 1));
                    if (o_tvalid_out) begin
                        if (i_tready_out) begin
                            got_q.push_back(o_tdata_out);
                        end else begin
                            stalled = 1'b1;
                            held = o_tdata_out;
                        end
                    end
                end
            end
        join
        checkOutput("rnd_count", 160'(got_q.size()), 160'(NUM_RAND));
        for (int i = 0; i < NUM_RAND; i++) begin
            exp_d = exp_q[i];
            checkOutput($sformatf("rnd_digest_%0d", i), (i < got_q.size()) ? got_q[i] : '0, exp_d);
        end
        i_tready_out = 1'b1;
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tvalid_out)
                extra++;
        end
        checkOutput("rnd_no_extra", 160'(extra), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha1_block_engine.md
Name: sha1_block_engine

Overview:
- Iterative SHA-1 compression core directly downstream of packet_alignment.
- Consumes already padded 512-bit message blocks on an AXI-Stream-style input. `i_tlast_in` marks the final block of a message.
- Runs one round per clock, 80 rounds per block, and chains the intermediate hash across blocks.
- Emits the 160-bit digest on a valid/ready output after the last block of each message.

Parameters:
- None. All SHA-1 constants live in sha1_pkg.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- o_tready_in  output  1  block engine can accept a block this cycle.
- i_tvalid_in  input  1  input block valid.
- i_tdata_in  input  512  message block; W0 = [511:480] ... W15 = [31:0]; big-endian, first message byte in [511:504].
- i_tlast_in  input  1  final block of the current message.
- i_tready_out  input  1  downstream accepts the digest.
- o_tvalid_out  output  1  digest valid.
- o_tdata_out  output  160  digest; H0 = [159:128] ... H4 = [31:0].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`reset_n`).
- Reset values:
  - o_tready_in = 0, o_tvalid_out = 0, o_tdata_out = 0.
  - State = IDLE, H = H_INIT, round counter = 0, last flag = 0.
  - o_tready_in rises on the first clock after reset release.
- FSM states are IDLE, ROUND, UPDATE, OUT.
  - IDLE: o_tready_in = 1. On i_tvalid_in && o_tready_in (cycle T), the engine loads and goes to ROUND:
    - W window[0..15] <= i_tdata_in;
    - A..E <= H;
    - last_flag <= i_tlast_in;
    - t <= 0.
  - ROUND: o_tready_in = 0. One round per cycle for t = 0..79, i.e. cycles T+1..T+80:
    - f/K: t<20 Ch, K=5A827999; t<40 Parity, K=6ED9EBA1; t<60 Maj, K=8F1BBCDC; else Parity, K=CA62C1D6.
    - temp = rotl5(A) + f(B,C,D) + E + K + Wt, modulo 2^32.
    - E<=D, D<=C, C<=rotl30(B), B<=A, A<=temp.
    - Wt is window[0]. The window shifts left by one word; the new word 15 = rotl1(w13 ^ w8 ^ w2 ^ w0), using current-window indices.
    - After t = 79, go to UPDATE.
  - UPDATE (cycle T+81): Hi <= Hi + {A..E}i, mod 2^32 per word.
    - If last_flag: o_tdata_out <= updated H, o_tvalid_out <= 1, H <= H_INIT, go to OUT.
    - Else: go to IDLE. The next block is accepted no earlier than T+82.
  - OUT: o_tvalid_out = 1, with o_tdata_out held stable until i_tready_out.
    - On handshake: o_tvalid_out <= 0, go to IDLE. o_tready_in = 1 from the next cycle.
    - No input is accepted while in OUT.
- Latency: the last block is accepted at T; o_tvalid_out = 1 at T+82.
  - Throughput is one block per 82 cycles, plus output-stall cycles.
- o_tready_in is registered and does not depend on i_tvalid_in. i_tready_out may toggle arbitrarily; o_tdata_out never changes while o_tvalid_out = 1 && !i_tready_out.
- Multi-block messages: H chains across non-last blocks and reinitialises only after a last block. Messages are back-to-back with no idle requirement beyond the FSM.
- Boundary conditions:
  - i_tvalid_in outside IDLE is ignored. Upstream must hold data per AXI rules.
  - Asynchronous reset mid-round or in OUT aborts everything: the partial digest is discarded, H = H_INIT, all outputs are forced to reset values immediately.
  - All adders are 32-bit wrap-around with no carry between words.
  - The round counter is 7 bits; it saturates only via the FSM transition at 79, with no wrap.

Decomposition:
- sha1_pkg contains:
  - H_INIT (67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0);
  - K constants;
  - FSM state enum;
  - functions rotl and f_sel(t, b, c, d).
- One sub-module, sha1_round: combinational single round taking (A..E, Wt, t) and producing (A'..E').
- Message-schedule window, counter, FSM and H registers stay in sha1_block_engine.

Test Plan:
- Empty message: block 80000000 followed by 14 zero words and 00000000 as word 15, tlast = 1.
  - Digest da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
  - o_tvalid_out rises exactly 82 cycles after acceptance.
- "abc": W0 = 61626380, W1..W14 = 0, W15 = 00000018, tlast = 1.
  - Digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits):
  - Block 1 with tlast = 0, then block 2 (80000000, zeros, W15 = 000001C0) with tlast = 1.
  - Single digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; no output after block 1.
- Output backpressure: "abc" followed by the empty message queued back-to-back, with i_tready_out held low for 20 cycles.
  - o_tdata_out holds the "abc" digest stable and o_tready_in stays 0 throughout.
  - After release, the second digest is da39a3ee... and H was reinitialised between messages.
- Reset mid-operation: assert reset_n = 0 at round t = 40 of the first "abc" attempt.
  - Outputs go to 0 immediately.
  - After release, "abc" is resent and the correct "abc" digest is produced (no stale state).
- Random valid gaps: stream 8 random padded messages against a reference model with random i_tvalid_in and i_tready_out throttling.
  - All digests match the model and each digest is seen exactly once.
